// File: rtl/calc_op_sequencer.sv
// Calculator operation engine: one shared sequential datapath computes
// add/sub in a single step and mul (shift-add) / div (restoring) in W steps.
module calc_op_sequencer #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic [W-1:0]   remainder,
  output logic           div_by_zero
);

  localparam int CW = $clog2(W) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     op_q, op_d;
  // opa: zero-extended A; shifts left as multiplicand or feeds dividend bits MSB first
  logic [2*W-1:0] opa_q, opa_d;
  // opb: multiplier (shifts right) or constant divisor
  logic [W-1:0]   opb_q, opb_d;
  // acc: running product, or quotient bits collected LSB-in
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [2*W-1:0] result_q, result_d;
  logic [W-1:0]   remainder_q, remainder_d;
  logic           dbz_q, dbz_d;

  logic [2*W-1:0] mul_acc;
  logic [W:0]     div_shift;
  logic [W:0]     div_diff;
  logic           div_take;
  logic [W-1:0]   div_rem;
  logic [2*W-1:0] div_quo;
  logic           last_step;

  // One iteration of each multi-cycle algorithm, evaluated from current state
  always_comb begin
    mul_acc   = acc_q + (opb_q[0] ? opa_q : '0);
    div_shift = {rem_q, opa_q[W-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_take  = (div_shift >= {1'b0, opb_q});
    div_rem   = div_take ? div_diff[W-1:0] : div_shift[W-1:0];
    div_quo   = {acc_q[2*W-2:0], div_take};
    last_step = (op_q == OP_ADD) || (op_q == OP_SUB) || (cnt_q == CW'(W - 1));
  end

  // Next-state logic: accept in IDLE, iterate in EXEC, publish at DONE entry
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = EXEC;
          cnt_d   = '0;
          op_d    = op;
          opa_d   = {{W{1'b0}}, a};
          opb_d   = b;
          acc_d   = '0;
          rem_d   = '0;
        end
      end
      EXEC: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q == OP_MUL) begin
          acc_d = mul_acc;
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
        end else if (op_q == OP_DIV) begin
          acc_d = div_quo;
          rem_d = div_rem;
          opa_d = opa_q << 1;
        end
        if (last_step) begin
          state_d     = DONE;
          remainder_d = '0;
          dbz_d       = 1'b0;
          case (op_q)
            OP_ADD:  result_d = opa_q + {{W{1'b0}}, opb_q};
            OP_SUB:  result_d = opa_q - {{W{1'b0}}, opb_q};
            OP_MUL:  result_d = mul_acc;
            default: begin
              // b==0 falls out naturally: every step "takes", quotient all ones, rem = a
              result_d    = {{W{1'b0}}, div_quo[W-1:0]};
              remainder_d = div_rem;
              dbz_d       = (opb_q == '0);
            end
          endcase
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, all cleared by reset (aborts any operation)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      result_q    <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign result      = result_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Bench for calc_op_sequencer: cycle-level reference model plus directed vectors.
module tb_calc_op_sequencer;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [1:0]     op = 2'b00;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
  logic [W-1:0]   remainder;
  logic           div_by_zero;

  int checks = 0;
  int errors = 0;

  calc_op_sequencer #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining-cycle countdown plus plain arithmetic results
  logic           m_busy, m_done, m_dbz, p_dbz;
  int             m_left;
  logic [2*W-1:0] m_res, p_res;
  logic [W-1:0]   m_rem, p_rem;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_done <= 0; m_left <= 0;
      m_res <= '0; m_rem <= '0; m_dbz <= 0;
      p_res <= '0; p_rem <= '0; p_dbz <= 0;
    end else if (m_done) begin
      m_done <= 0;
      m_busy <= 0;
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_done <= 1;
        m_res <= p_res; m_rem <= p_rem; m_dbz <= p_dbz;
      end else begin
        m_left <= m_left - 1;
      end
    end else if (start) begin
      m_busy <= 1;
      m_left <= (op == 2'b00 || op == 2'b01) ? 1 : W;
      p_rem  <= '0;
      p_dbz  <= 0;
      case (op)
        2'b00: p_res <= (2*W)'(int'(a) + int'(b));
        2'b01: p_res <= (2*W)'(int'(a) - int'(b));
        2'b11: p_res <= (2*W)'(int'(a) * int'(b));
        default: begin
          if (b == 0) begin
            p_res <= (2*W)'((1 << W) - 1);
            p_rem <= a;
            p_dbz <= 1;
          end else begin
            p_res <= (2*W)'(int'(a) / int'(b));
            p_rem <= W'(int'(a) % int'(b));
          end
        end
      endcase
    end
  end

  // Every-cycle comparison of DUT against the model
  always @(negedge clk) begin
    check("model_busy", busy, m_busy);
    check("model_done", done, m_done);
    check("model_result", result, m_res);
    check("model_remainder", remainder, m_rem);
    check("model_dbz", div_by_zero, m_dbz);
  end

  // Issue one op and check latency, busy width, held result and literal outputs
  task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] va,
                        input logic [W-1:0] vb, input int exp_res, input int exp_rem,
                        input int exp_dbz, input int exp_lat);
    logic [2*W-1:0] prev;
    int lat, busy_cnt;
    prev = result;
    op = o; a = va; b = vb; start = 1;
    @(negedge clk);
    start = 0;
    a = ~va; b = ~vb;
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
      if (done || lat > 20) break;
      if (result != prev) check({name, "_held"}, result, prev);
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_result"}, result, exp_res);
    check({name, "_rem"}, remainder, exp_rem);
    check({name, "_dbz"}, div_by_zero, exp_dbz);
    @(negedge clk);
    check({name, "_done_1cyc"}, done, 0);
    check({name, "_busy_cycles"}, busy_cnt, exp_lat + 1);
  endtask

  initial begin
    int lat;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    check("reset_rem", remainder, 0);
    check("reset_dbz", div_by_zero, 0);
    #2 rst_n = 1;
    @(negedge clk);

    run_op("add_9_7",  2'b00, 4'd9,  4'd7,  'h10, 0, 0, 1);
    run_op("sub_3_5",  2'b01, 4'd3,  4'd5,  'hFE, 0, 0, 1);
    run_op("sub_5_3",  2'b01, 4'd5,  4'd3,  'h02, 0, 0, 1);
    run_op("mul_15_15", 2'b11, 4'd15, 4'd15, 'hE1, 0, 0, 4);
    run_op("div_13_4", 2'b10, 4'd13, 4'd4,  'h03, 1, 0, 4);
    run_op("div_9_0",  2'b10, 4'd9,  4'd0,  'h0F, 9, 1, 4);
    run_op("mul_0_7",  2'b11, 4'd0,  4'd7,  'h00, 0, 0, 4);
    run_op("div_15_15", 2'b10, 4'd15, 4'd15, 'h01, 0, 0, 4);

    // start held high while operands churn: only the accepted request counts
    op = 2'b11; a = 4'd15; b = 4'd15; start = 1;
    @(negedge clk);
    lat = 0;
    while (1) begin
      a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15));
      @(negedge clk);
      lat++;
      if (done || lat > 20) break;
    end
    check("held_start_latency", lat, 4);
    check("held_start_result", result, 'hE1);
    @(negedge clk);
    check("held_start_done_drop", done, 0);
    check("held_start_idle_gap", busy, 0);
    @(negedge clk);
    check("held_start_reaccept", busy, 1);
    start = 0;
    lat = 0;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    check("held_start_second_done", done, 1);
    @(negedge clk);
    @(negedge clk);

    // reset in the 2nd EXEC cycle of a mul
    op = 2'b11; a = 4'd7; b = 4'd6; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_rem", remainder, 0);
    check("abort_dbz", div_by_zero, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    check("abort_no_done", done, 0);
    run_op("add_1_1", 2'b00, 4'd1, 4'd1, 'h02, 0, 0, 1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
